// File: rtl/decode_hazard_unit.sv
// decode_hazard_unit: register hazard control between decode and EX/MEM/WB.
// Decodes the destination and sources of the instruction in the decode slot.
// A per-stage scoreboard tracks in-flight writes.
// From these it produces the stall, the operand forwarding selects, the
// mul/div freeze and the writeback strobe.
//
// Handshake: the decode slot offers an instruction with dec_valid. It is
// accepted (issue=1) on the rising edge only when neither stall nor flush is
// asserted. When stall=1 the slot must hold the same instruction.
module decode_hazard_unit #(
    parameter int REG_W      = 5,
    parameter int NUM_STAGES = 3,
    parameter int MULDIV_LAT = 32,
    parameter int STATUS_REG = 30,
    parameter int RA_REG     = 31,
    parameter int FW         = $clog2(NUM_STAGES + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             dec_valid,
    input  logic [4:0]       dec_opcode,
    input  logic [4:0]       dec_aluop,
    input  logic [REG_W-1:0] dec_rd,
    input  logic [REG_W-1:0] dec_rs,
    input  logic [REG_W-1:0] dec_rt,
    input  logic             flush,
    output logic             stall,
    output logic             issue,
    output logic [FW-1:0]    fwd_a_sel,
    output logic [FW-1:0]    fwd_b_sel,
    output logic             muldiv_busy,
    output logic             wb_we,
    output logic [REG_W-1:0] wb_reg
);

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    // MULDIV_LAT-1 is the largest counter value; keep at least one bit.
    localparam int CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);

    // Scoreboard: index 0 = EX, NUM_STAGES-1 = WB.
    logic [NUM_STAGES-1:0] valid_q;
    logic [NUM_STAGES-1:0] load_q;
    logic [REG_W-1:0]      reg_q [NUM_STAGES];
    logic [CNT_W-1:0]      cnt_q;

    logic             is_r, is_lw, is_muldiv, use_a, use_b;
    logic             dest_en, new_valid;
    logic [REG_W-1:0] dest, src_b;
    logic [NUM_STAGES-1:0] hit_a, hit_b;
    logic             load_use;

    assign is_r      = (dec_opcode == OP_R);
    assign is_lw     = (dec_opcode == OP_LW);
    assign is_muldiv = is_r && ((dec_aluop == ALU_MUL) || (dec_aluop == ALU_DIV));
    assign use_a     = is_r || (dec_opcode == OP_ADDI) || is_lw || (dec_opcode == OP_SW) ||
                       (dec_opcode == OP_BNE) || (dec_opcode == OP_BLT);
    assign use_b     = is_r || (dec_opcode == OP_SW) || (dec_opcode == OP_BNE) ||
                       (dec_opcode == OP_BLT) || (dec_opcode == OP_JR);
    assign src_b     = is_r ? dec_rt : dec_rd;

    // Destination decode; jal and setx write fixed registers.
    always_comb begin
        dest_en = 1'b0;
        dest    = dec_rd;
        case (dec_opcode)
            OP_R, OP_ADDI, OP_LW: dest_en = 1'b1;
            OP_JAL: begin
                dest_en = 1'b1;
                dest    = REG_W'(RA_REG);
            end
            OP_SETX: begin
                dest_en = 1'b1;
                dest    = REG_W'(STATUS_REG);
            end
            default: dest_en = 1'b0;
        endcase
    end

    // Per-stage source matches; register 0 never matches.
    always_comb begin
        hit_a = '0;
        hit_b = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            hit_a[k] = use_a && (dec_rs != '0) && valid_q[k] && (reg_q[k] == dec_rs);
            hit_b[k] = use_b && (src_b != '0) && valid_q[k] && (reg_q[k] == src_b);
        end
    end

    // Forward from the youngest matching stage; a load still in EX has no data yet.
    always_comb begin
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (hit_a[k]) fwd_a_sel = FW'(k + 1);
            if (hit_b[k]) fwd_b_sel = FW'(k + 1);
        end
        if (hit_a[0] && load_q[0]) fwd_a_sel = '0;
        if (hit_b[0] && load_q[0]) fwd_b_sel = '0;
    end

    assign load_use    = dec_valid && load_q[0] && (hit_a[0] || hit_b[0]);
    assign muldiv_busy = (cnt_q != '0);
    assign stall       = !flush && (load_use || muldiv_busy);
    assign issue       = reset_n && dec_valid && !stall && !flush;
    assign new_valid   = issue && dest_en && (dest != '0);
    assign wb_we       = valid_q[NUM_STAGES-1];
    assign wb_reg      = valid_q[NUM_STAGES-1] ? reg_q[NUM_STAGES-1] : '0;

    // Scoreboard shift; frozen during mul/div, where flush only kills stage 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            load_q  <= '0;
            for (int k = 0; k < NUM_STAGES; k++) reg_q[k] <= '0;
        end else if (!muldiv_busy) begin
            valid_q <= {valid_q[NUM_STAGES-2:0], new_valid};
            load_q  <= {load_q[NUM_STAGES-2:0], new_valid && is_lw};
            reg_q[0] <= dest;
            for (int k = 1; k < NUM_STAGES; k++) reg_q[k] <= reg_q[k-1];
        end else if (flush) begin
            valid_q[0] <= 1'b0;
        end
    end

    // Mul/div freeze counter; flush abandons the operation.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end else if (issue && is_muldiv) begin
            cnt_q <= CNT_LOAD;
        end
    end

endmodule

// File: tb/tb_decode_hazard_unit.sv
// Bench for decode_hazard_unit with NUM_STAGES=3, MULDIV_LAT=4.
// Each table row is one decode cycle: inputs plus the outputs expected
// before the following rising edge.
module tb_decode_hazard_unit;

    localparam logic [4:0] R    = 5'b00000;
    localparam logic [4:0] LW   = 5'b01000;
    localparam logic [4:0] SW   = 5'b00111;
    localparam logic [4:0] JAL  = 5'b00011;
    localparam logic [4:0] SETX = 5'b10101;
    localparam logic [4:0] MUL  = 5'b00110;

    typedef struct {
        logic       v;
        logic [4:0] op, alu, rd, rs, rt;
        logic       fl;
        logic       e_stall, e_issue;
        logic [1:0] e_fa, e_fb;
        logic       e_busy, e_we;
        logic [4:0] e_wr;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       dec_valid, flush;
    logic [4:0] dec_opcode, dec_aluop, dec_rd, dec_rs, dec_rt;
    logic       stall, issue, muldiv_busy, wb_we;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [4:0] wb_reg;

    int total = 0;
    int bad   = 0;

    vec_t tbl [30];
    vec_t seq [6];

    decode_hazard_unit #(
        .REG_W(5), .NUM_STAGES(3), .MULDIV_LAT(4), .STATUS_REG(30), .RA_REG(31)
    ) dut (
        .clock(clock), .reset_n(reset_n), .dec_valid(dec_valid),
        .dec_opcode(dec_opcode), .dec_aluop(dec_aluop), .dec_rd(dec_rd),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .flush(flush), .stall(stall),
        .issue(issue), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .muldiv_busy(muldiv_busy), .wb_we(wb_we), .wb_reg(wb_reg)
    );

    // Clock
    always #5 clock = ~clock;

    function automatic vec_t mk(logic v, logic [4:0] op, logic [4:0] alu, logic [4:0] rd,
                                logic [4:0] rs, logic [4:0] rt, logic fl, logic st,
                                logic is, logic [1:0] fa, logic [1:0] fb, logic bz,
                                logic we, logic [4:0] wr);
        vec_t t;
        t.v = v; t.op = op; t.alu = alu; t.rd = rd; t.rs = rs; t.rt = rt; t.fl = fl;
        t.e_stall = st; t.e_issue = is; t.e_fa = fa; t.e_fb = fb;
        t.e_busy = bz; t.e_we = we; t.e_wr = wr;
        return t;
    endfunction

    function automatic vec_t bubble(logic we, logic [4:0] wr);
        return mk(1'b0, R, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, we, wr);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, got, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        dec_valid  = t.v;
        dec_opcode = t.op;
        dec_aluop  = t.alu;
        dec_rd     = t.rd;
        dec_rs     = t.rs;
        dec_rt     = t.rt;
        flush      = t.fl;
    endtask

    task automatic check_out(input vec_t t, input string tag, input int idx);
        chk({tag, ".stall"},  idx, 32'(stall),       32'(t.e_stall));
        chk({tag, ".issue"},  idx, 32'(issue),       32'(t.e_issue));
        chk({tag, ".fwd_a"},  idx, 32'(fwd_a_sel),   32'(t.e_fa));
        chk({tag, ".fwd_b"},  idx, 32'(fwd_b_sel),   32'(t.e_fb));
        chk({tag, ".busy"},   idx, 32'(muldiv_busy), 32'(t.e_busy));
        chk({tag, ".wb_we"},  idx, 32'(wb_we),       32'(t.e_we));
        chk({tag, ".wb_reg"}, idx, 32'(wb_reg),      32'(t.e_wr));
    endtask

    // One decode cycle: drive, check mid-cycle, then cross the rising edge.
    task automatic run_row(input vec_t t, input string tag, input int idx);
        drive(t);
        #3;
        check_out(t, tag, idx);
        @(posedge clock);
        #1;
    endtask

    initial begin
        vec_t z;
        // Forwarding, writeback timing, load-use
        tbl[0]  = mk(1, R,    0,  3,  1, 2, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, R,    0,  4,  3, 3, 0, 0, 1, 1, 1, 0, 0, 0);
        tbl[2]  = bubble(0, 0);
        tbl[3]  = bubble(1, 3);
        tbl[4]  = mk(1, LW,   0,  5,  0, 0, 0, 0, 1, 0, 0, 0, 1, 4);
        tbl[5]  = mk(1, R,    0,  6,  5, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, R,    0,  6,  5, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        // Mul freeze for 3 cycles, then the dependent add issues
        tbl[7]  = mk(1, R,    MUL, 7, 1, 2, 0, 0, 1, 0, 0, 0, 1, 5);
        tbl[8]  = mk(1, R,    0, 10,  7, 0, 0, 1, 0, 1, 0, 1, 0, 0);
        tbl[9]  = mk(1, R,    0, 10,  7, 0, 0, 1, 0, 1, 0, 1, 0, 0);
        tbl[10] = mk(1, R,    0, 10,  7, 0, 0, 1, 0, 1, 0, 1, 0, 0);
        tbl[11] = mk(1, R,    0, 10,  7, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        tbl[12] = bubble(1, 6);
        tbl[13] = bubble(1, 7);
        // Register 0 destination and sources
        tbl[14] = mk(1, R,    0,  0,  1, 2, 0, 0, 1, 0, 0, 0, 1, 10);
        tbl[15] = mk(1, R,    0,  8,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[16] = bubble(0, 0);
        tbl[17] = bubble(0, 0);
        // jal / setx implicit destinations, sw source B = rd
        tbl[18] = mk(1, JAL,  0,  0,  0, 0, 0, 0, 1, 0, 0, 0, 1, 8);
        tbl[19] = mk(1, R,    0,  9, 31, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        tbl[20] = mk(1, SETX, 0,  0,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[21] = mk(1, R,    0, 11, 30, 9, 0, 0, 1, 1, 2, 0, 1, 31);
        tbl[22] = mk(1, SW,   0,  9, 11, 0, 0, 0, 1, 1, 3, 0, 1, 9);
        tbl[23] = bubble(1, 30);
        // Flush during the mul freeze
        tbl[24] = mk(1, R,    MUL, 12, 1, 2, 0, 0, 1, 0, 0, 0, 1, 11);
        tbl[25] = mk(1, R,    0, 13, 12, 0, 1, 0, 0, 1, 0, 1, 0, 0);
        tbl[26] = mk(1, R,    0, 13, 12, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[27] = bubble(0, 0);
        tbl[28] = bubble(0, 0);
        tbl[29] = bubble(1, 13);

        // Reset during a freeze, then first issue right after release
        seq[0] = mk(1, R, 0,   14,  1,  2, 0, 0, 1, 0, 0, 0, 0, 0);
        seq[1] = mk(1, R, 0,   15,  1,  2, 0, 0, 1, 0, 0, 0, 0, 0);
        seq[2] = mk(1, R, MUL, 16, 14, 15, 0, 0, 1, 2, 1, 0, 0, 0);
        seq[3] = mk(1, R, 0,   17, 16, 14, 0, 1, 0, 1, 3, 1, 1, 14);
        seq[4] = mk(1, R, 0,   20, 16,  0, 0, 0, 1, 0, 0, 0, 0, 0);
        seq[5] = mk(1, R, 0,   21, 20,  0, 0, 0, 1, 1, 0, 0, 0, 0);

        // Reset with a valid slot offered: everything must read zero
        reset_n = 1'b0;
        drive(tbl[0]);
        repeat (2) @(posedge clock);
        #1;
        z = mk(1, R, 0, 3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        check_out(z, "reset", 0);
        #2;
        reset_n = 1'b1;

        for (int i = 0; i < 30; i++) run_row(tbl[i], "tbl", i);

        for (int i = 0; i < 3; i++) run_row(seq[i], "seq", i);
        drive(seq[3]);
        #3;
        check_out(seq[3], "pre_rst", 3);
        reset_n = 1'b0;
        #1;
        z = mk(1, R, 0, 17, 16, 14, 0, 0, 0, 0, 0, 0, 0, 0);
        check_out(z, "async_rst", 0);
        @(posedge clock);
        #1;
        check_out(z, "held_rst", 0);
        #2;
        reset_n = 1'b1;
        run_row(seq[4], "post_rst", 4);
        run_row(seq[5], "post_rst", 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
